// File: rtl/memwb_stage_if.sv
// EX/MEM -> MEM/WB bus bundle for memwb_stage.
// master = upstream pipeline / writeback side, slave = the stage itself.
interface memwb_stage_if;
  logic [3:0]  ctrl_MEM;
  logic [31:0] ALU_out_MEM;
  logic [31:0] write_data_MEM;
  logic [4:0]  reg_dst_MEM;
  logic        mem_stall;
  logic [1:0]  ctrl_WB;
  logic [31:0] read_data_WB;
  logic [31:0] ALU_out_WB;
  logic [4:0]  reg_dst_WB;
  logic        misalign_WB;

  modport master (
    output ctrl_MEM, ALU_out_MEM, write_data_MEM, reg_dst_MEM,
    input  mem_stall, ctrl_WB, read_data_WB, ALU_out_WB, reg_dst_WB, misalign_WB
  );

  modport slave (
    input  ctrl_MEM, ALU_out_MEM, write_data_MEM, reg_dst_MEM,
    output mem_stall, ctrl_WB, read_data_WB, ALU_out_WB, reg_dst_WB, misalign_WB
  );
endinterface

// File: rtl/memwb_stage.sv
// MEM stage with fixed-latency data memory and MEM/WB pipeline register.
// Optional MEM_MISALIGN_CHECK_EN: flags misaligned accesses, suppresses stores, returns 0.
//
// state | meaning
// IDLE  | no access in flight; ALU ops and zero-latency accesses commit here
// BUSY  | access in flight; cnt counts remaining stall cycles, commit at cnt==0
module memwb_stage #(
  parameter int MEM_WORDS   = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  memwb_stage_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1 = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem [MEM_WORDS];

  logic             access, is_store, misal, commit, stall, mem_we;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rdata;

  logic [1:0]  ctrl_wb_q, ctrl_wb_d;
  logic [31:0] read_data_wb_q, read_data_wb_d;
  logic [31:0] alu_out_wb_q, alu_out_wb_d;
  logic [4:0]  reg_dst_wb_q, reg_dst_wb_d;
  logic        misalign_wb_q, misalign_wb_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ALU_out_MEM[31:IDX_W+2], bus.ALU_out_MEM[1:0]};

  always_comb begin
    access   = bus.ctrl_MEM[1] | bus.ctrl_MEM[0];
    is_store = bus.ctrl_MEM[0];
    idx      = bus.ALU_out_MEM[IDX_W+1:2];
`ifdef MEM_MISALIGN_CHECK_EN
    misal    = access & (bus.ALU_out_MEM[1:0] != 2'b00);
`else
    misal    = 1'b0;
`endif
    rdata    = misal ? 32'h0 : mem[idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access && (MEM_LATENCY > 0)) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
          stall   = 1'b1;
        end else begin
          commit  = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          stall = 1'b1;
        end else begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the write so an interrupted completion cycle never lands in memory.
  assign mem_we = commit & is_store & ~misal & ~reset;

  always_comb begin
    ctrl_wb_d      = 2'b00;
    misalign_wb_d  = 1'b0;
    read_data_wb_d = read_data_wb_q;
    alu_out_wb_d   = alu_out_wb_q;
    reg_dst_wb_d   = reg_dst_wb_q;
    if (!stall) begin
      ctrl_wb_d      = bus.ctrl_MEM[3:2];
      misalign_wb_d  = misal;
      read_data_wb_d = rdata;
      alu_out_wb_d   = bus.ALU_out_MEM;
      reg_dst_wb_d   = bus.reg_dst_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      ctrl_wb_q      <= 2'b00;
      read_data_wb_q <= 32'h0;
      alu_out_wb_q   <= 32'h0;
      reg_dst_wb_q   <= 5'd0;
      misalign_wb_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ctrl_wb_q      <= ctrl_wb_d;
      read_data_wb_q <= read_data_wb_d;
      alu_out_wb_q   <= alu_out_wb_d;
      reg_dst_wb_q   <= reg_dst_wb_d;
      misalign_wb_q  <= misalign_wb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= bus.write_data_MEM;
  end

  assign bus.mem_stall    = stall;
  assign bus.ctrl_WB      = ctrl_wb_q;
  assign bus.read_data_WB = read_data_wb_q;
  assign bus.ALU_out_WB   = alu_out_wb_q;
  assign bus.reg_dst_WB   = reg_dst_wb_q;
  assign bus.misalign_WB  = misalign_wb_q;
endmodule

// File: tb/tb_memwb_stage.sv
// Directed bench for memwb_stage: default-latency instance plus a zero-latency instance.
module tb_memwb_stage;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  memwb_stage_if bus ();
  memwb_stage_if bus_z ();

  memwb_stage #(.MEM_WORDS(64), .MEM_LATENCY(2)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  memwb_stage #(.MEM_WORDS(64), .MEM_LATENCY(0)) u_z   (.clk(clk), .reset(reset), .bus(bus_z));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one instruction to the default-latency DUT and runs it to MEM/WB capture.
  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                    input logic [4:0] rd, output int stalls, output logic [1:0] ctrl_done);
    bus.ctrl_MEM       = c;
    bus.ALU_out_MEM    = a;
    bus.write_data_MEM = wd;
    bus.reg_dst_MEM    = rd;
    stalls = 0;
    #1;
    while (bus.mem_stall && stalls < 20) begin
      stalls++;
      @(posedge clk); #1;
    end
    ctrl_done = bus.ctrl_WB;
    @(posedge clk); #1;
    bus.ctrl_MEM = 4'b0000;
  endtask

  task automatic step_z(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd);
    bus_z.ctrl_MEM       = c;
    bus_z.ALU_out_MEM    = a;
    bus_z.write_data_MEM = wd;
    bus_z.reg_dst_MEM    = rd;
    #1;
    check("z_stall", 32'(bus_z.mem_stall), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int         st;
    logic [1:0] cd;

    reset = 1'b1;
    bus.ctrl_MEM = 4'b0; bus.ALU_out_MEM = 32'h0; bus.write_data_MEM = 32'h0; bus.reg_dst_MEM = 5'd0;
    bus_z.ctrl_MEM = 4'b0; bus_z.ALU_out_MEM = 32'h0; bus_z.write_data_MEM = 32'h0; bus_z.reg_dst_MEM = 5'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_ctrl_wb",  32'(bus.ctrl_WB), 32'd0);
    check("rst_rdata_wb", bus.read_data_WB, 32'h0);
    check("rst_alu_wb",   bus.ALU_out_WB, 32'h0);
    check("rst_rdst_wb",  32'(bus.reg_dst_WB), 32'd0);
    check("rst_misal_wb", 32'(bus.misalign_WB), 32'd0);
    check("rst_stall",    32'(bus.mem_stall), 32'd0);
    @(posedge clk); #1;

    op(4'b0001, 32'h10, 32'hDEADBEEF, 5'd0, st, cd);
    check("st10_stalls", 32'(st), 32'd2);
    check("st10_bubble", 32'(cd), 32'd0);
    check("st10_ctrl",   32'(bus.ctrl_WB), 32'd0);

    op(4'b1110, 32'h10, 32'h0, 5'd3, st, cd);
    check("ld10_stalls", 32'(st), 32'd2);
    check("ld10_bubble", 32'(cd), 32'd0);
    check("ld10_data",   bus.read_data_WB, 32'hDEADBEEF);
    check("ld10_ctrl",   32'(bus.ctrl_WB), 32'd3);
    check("ld10_rdst",   32'(bus.reg_dst_WB), 32'd3);
    check("ld10_alu",    bus.ALU_out_WB, 32'h10);

    op(4'b1000, 32'h1234, 32'h0, 5'd5, st, cd);
    check("alu_stalls", 32'(st), 32'd0);
    check("alu_out",    bus.ALU_out_WB, 32'h1234);
    check("alu_rdst",   32'(bus.reg_dst_WB), 32'd5);
    check("alu_ctrl",   32'(bus.ctrl_WB), 32'd2);

    op(4'b0001, 32'h100, 32'hCAFEF00D, 5'd0, st, cd);
    op(4'b1110, 32'h0, 32'h0, 5'd7, st, cd);
    check("wrap_data", bus.read_data_WB, 32'hCAFEF00D);

    op(4'b0001, 32'h20, 32'h11, 5'd0, st, cd);
    bus.ctrl_MEM = 4'b0001; bus.ALU_out_MEM = 32'h20; bus.write_data_MEM = 32'h55;
    #1;
    check("rstmid_stall0", 32'(bus.mem_stall), 32'd1);
    @(posedge clk); #1;
    check("rstmid_busy", 32'(bus.mem_stall), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.ctrl_MEM = 4'b0000;
    #1;
    check("rstmid_stall", 32'(bus.mem_stall), 32'd0);
    check("rstmid_ctrl",  32'(bus.ctrl_WB), 32'd0);
    check("rstmid_alu",   bus.ALU_out_WB, 32'h0);
    op(4'b1110, 32'h20, 32'h0, 5'd1, st, cd);
    check("rstmid_old", bus.read_data_WB, 32'h11);

    op(4'b0001, 32'h22, 32'h77, 5'd0, st, cd);
    check("mis_st_stalls", 32'(st), 32'd2);
`ifdef MEM_MISALIGN_CHECK_EN
    check("mis_st_flag", 32'(bus.misalign_WB), 32'd1);
    op(4'b1110, 32'h20, 32'h0, 5'd1, st, cd);
    check("mis_mem", bus.read_data_WB, 32'h11);
    check("mis_ld_ok_flag", 32'(bus.misalign_WB), 32'd0);
    op(4'b1110, 32'h22, 32'h0, 5'd1, st, cd);
    check("mis_ld_data", bus.read_data_WB, 32'h0);
    check("mis_ld_flag", 32'(bus.misalign_WB), 32'd1);
`else
    check("mis_st_flag", 32'(bus.misalign_WB), 32'd0);
    op(4'b1110, 32'h20, 32'h0, 5'd1, st, cd);
    check("mis_mem", bus.read_data_WB, 32'h77);
`endif

    step_z(4'b0001, 32'h8, 32'hA5A5A5A5, 5'd0);
    check("z_st1_ctrl", 32'(bus_z.ctrl_WB), 32'd0);
    step_z(4'b1110, 32'h8, 32'h0, 5'd4);
    check("z_ld1_data", bus_z.read_data_WB, 32'hA5A5A5A5);
    check("z_ld1_ctrl", 32'(bus_z.ctrl_WB), 32'd3);
    step_z(4'b0001, 32'h8, 32'h12345678, 5'd0);
    check("z_st2_ctrl", 32'(bus_z.ctrl_WB), 32'd0);
    step_z(4'b1110, 32'h8, 32'h0, 5'd6);
    check("z_ld2_data", bus_z.read_data_WB, 32'h12345678);
    check("z_ld2_rdst", 32'(bus_z.reg_dst_WB), 32'd6);
    bus_z.ctrl_MEM = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
